// File: rtl/rx_uart_lite.sv
// rx_uart_lite: minimal 8N1 UART receiver.
//
// Ports:
//   i_clk      - sole clock, rising edge
//   i_rst_n    - synchronous active-low reset
//   i_uart_rx  - asynchronous serial input, idle high
//   o_wr       - one-cycle strobe, o_data holds a freshly received byte
//   o_data     - last correctly framed byte; held between strobes
//
// Parameter:
//   CLOCKS_PER_BAUD - clock cycles per bit period (4 or more)
module rx_uart_lite #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // The counter is loaded one short of the interval because the cycle in
  // which it reads zero is itself the sample cycle.
  localparam logic [23:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] BAUD_LOAD = CLOCKS_PER_BAUD - 24'd1;

  state_t      state;
  state_t      state_next;
  logic        rx_meta;
  logic        rx_s;
  logic [23:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        tick;

  logic        load_half;
  logic        load_baud;
  logic        shift_en;
  logic        capture;

  assign tick = (baud_cnt == '0);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:      if (tick && (bit_cnt == 3'd7)) state_next = STOP;
      STOP:      if (tick) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_baud = 1'b0;
    shift_en  = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE:  load_half = !rx_s;
      START: load_baud = tick && !rx_s;
      DATA: begin
        load_baud = tick;
        shift_en  = tick;
      end
      STOP:  capture = tick && rx_s;
      default: ;
    endcase
  end

  // After the stop sample the counter is left at zero, so it idles there
  // until the next start edge reloads it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_wr     <= 1'b0;
      o_data   <= '0;
    end else begin
      if (load_half) begin
        baud_cnt <= HALF_LOAD;
      end else if (load_baud) begin
        baud_cnt <= BAUD_LOAD;
      end else if (!tick) begin
        baud_cnt <= baud_cnt - 24'd1;
      end

      if (load_half) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
      end

      o_wr <= capture;
      if (capture) begin
        o_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_rx_uart_lite.sv
// tb_rx_uart_lite: directed self-checking bench for rx_uart_lite (CPB=104).
//
// A monitor logs every o_wr pulse (cycle index and byte); scenario tasks drive
// the serial line and compare the log against hand-computed expectations.
module tb_rx_uart_lite;

  localparam int unsigned CPB = 104;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_uart_rx;
  logic       o_wr;
  logic [7:0] o_data;

  int unsigned checks;
  int unsigned fails;

  int unsigned cyc;
  int unsigned pulse_cyc[$];
  logic [7:0]  pulse_dat[$];
  int unsigned dbl_pulse;
  int unsigned bad_change;
  logic        prev_wr;
  logic [7:0]  prev_data;
  logic        prev_rst_n;

  rx_uart_lite #(.CLOCKS_PER_BAUD(24'd104)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_uart_rx (i_uart_rx),
    .o_wr      (o_wr),
    .o_data    (o_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulse logger plus protocol watchers: o_wr never two cycles in a row,
  // o_data only changes together with o_wr (reset excepted).
  always @(negedge i_clk) begin
    if (o_wr === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(o_data);
      if (prev_wr === 1'b1) dbl_pulse++;
    end
    if (i_rst_n && prev_rst_n && (o_data !== prev_data) && (o_wr !== 1'b1))
      bad_change++;
    prev_wr    = o_wr;
    prev_data  = o_data;
    prev_rst_n = i_rst_n;
  end

  task automatic drive_bit(input logic b);
    i_uart_rx = b;
    repeat (CPB) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int unsigned n);
    i_uart_rx = 1'b1;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_dat.delete();
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    i_uart_rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_wr !== 1'b0 || o_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_hold[%0d]: o_wr=%b o_data=%h, want o_wr=0 o_data=00", i, o_wr, o_data);
      end
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_wr !== 1'b0 || o_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_release[%0d]: o_wr=%b o_data=%h, want o_wr=0 o_data=00", i, o_wr, o_data);
      end
    end
    @(posedge i_clk);
    #1;
    clear_log();
  endtask

  task automatic test_single_byte();
    int unsigned t0;
    clear_log();
    send_frame(8'h55, 1'b1, t0);
    idle(20);
    checks++;
    if (pulse_cyc.size() != 1) begin
      fails++;
      $display("FAIL single_count: got %0d pulses, want 1", pulse_cyc.size());
    end else begin
      checks++;
      if (pulse_cyc[0] != t0 + 991) begin
        fails++;
        $display("FAIL single_latency: pulse at T+%0d, want T+991", pulse_cyc[0] - t0);
      end
      checks++;
      if (pulse_dat[0] !== 8'h55) begin
        fails++;
        $display("FAIL single_data: got %h, want 55", pulse_dat[0]);
      end
    end
    checks++;
    if (o_data !== 8'h55) begin
      fails++;
      $display("FAIL single_hold: o_data=%h, want 55", o_data);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned ta;
    int unsigned tb;
    clear_log();
    send_frame(8'h00, 1'b1, ta);
    send_frame(8'hFF, 1'b1, tb);
    idle(20);
    checks++;
    if (pulse_cyc.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses, want 2", pulse_cyc.size());
    end else begin
      checks++;
      if (pulse_cyc[1] - pulse_cyc[0] != 1040) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d cycles, want 1040", pulse_cyc[1] - pulse_cyc[0]);
      end
      checks++;
      if (pulse_cyc[0] != ta + 991) begin
        fails++;
        $display("FAIL b2b_latency: first pulse at T+%0d, want T+991", pulse_cyc[0] - ta);
      end
      checks++;
      if (pulse_dat[0] !== 8'h00 || pulse_dat[1] !== 8'hFF) begin
        fails++;
        $display("FAIL b2b_data: got %h,%h, want 00,FF", pulse_dat[0], pulse_dat[1]);
      end
    end
  endtask

  task automatic test_glitch();
    int unsigned t0;
    clear_log();
    i_uart_rx = 1'b0;
    repeat (30) begin
      @(posedge i_clk);
      #1;
    end
    idle(300);
    checks++;
    if (pulse_cyc.size() != 0 || o_data !== 8'hFF) begin
      fails++;
      $display("FAIL glitch_reject: pulses=%0d o_data=%h, want 0 pulses o_data=FF", pulse_cyc.size(), o_data);
    end
    send_frame(8'hA5, 1'b1, t0);
    idle(20);
    checks++;
    if (pulse_cyc.size() != 1 || pulse_dat[0] !== 8'hA5 || pulse_cyc[0] != t0 + 991) begin
      fails++;
      $display("FAIL glitch_next: pulses=%0d o_data=%h, want one pulse of A5 at T+991", pulse_cyc.size(), o_data);
    end
  endtask

  task automatic test_framing_error();
    int unsigned t0;
    clear_log();
    send_frame(8'h3C, 1'b0, t0);
    i_uart_rx = 1'b0;
    repeat (2000) begin
      @(posedge i_clk);
      #1;
    end
    idle(50);
    checks++;
    if (pulse_cyc.size() != 0) begin
      fails++;
      $display("FAIL framing_no_wr: got %0d pulses, want 0", pulse_cyc.size());
    end
    checks++;
    if (o_data !== 8'hA5) begin
      fails++;
      $display("FAIL framing_hold: o_data=%h, want A5", o_data);
    end
    send_frame(8'hC3, 1'b1, t0);
    idle(20);
    checks++;
    if (pulse_cyc.size() != 1 || pulse_dat[0] !== 8'hC3 || pulse_cyc[0] != t0 + 991) begin
      fails++;
      $display("FAIL framing_next: pulses=%0d o_data=%h, want one pulse of C3 at T+991", pulse_cyc.size(), o_data);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned t0;
    logic [7:0] partial;
    partial = 8'hF0;
    clear_log();
    // Start bit and data bits 0..3, then halfway into bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    i_uart_rx = partial[4];
    repeat (CPB / 2) begin
      @(posedge i_clk);
      #1;
    end
    i_rst_n = 1'b0;
    repeat (5) begin
      @(posedge i_clk);
      #1;
    end
    i_rst_n = 1'b1;
    repeat (CPB / 2) begin
      @(posedge i_clk);
      #1;
    end
    for (int i = 5; i < 8; i++) drive_bit(partial[i]);
    drive_bit(1'b1);
    idle(300);
    checks++;
    if (pulse_cyc.size() != 0) begin
      fails++;
      $display("FAIL rst_mid_no_wr: got %0d pulses, want 0", pulse_cyc.size());
    end
    checks++;
    if (o_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_data: o_data=%h, want 00", o_data);
    end
    send_frame(8'h81, 1'b1, t0);
    idle(20);
    checks++;
    if (pulse_cyc.size() != 1 || pulse_dat[0] !== 8'h81 || pulse_cyc[0] != t0 + 991) begin
      fails++;
      $display("FAIL rst_mid_next: pulses=%0d o_data=%h, want one pulse of 81 at T+991", pulse_cyc.size(), o_data);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (dbl_pulse != 0) begin
      fails++;
      $display("FAIL wr_single_cycle: %0d consecutive-high events, want 0", dbl_pulse);
    end
    checks++;
    if (bad_change != 0) begin
      fails++;
      $display("FAIL data_stable: %0d changes without o_wr, want 0", bad_change);
    end
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    cyc        = 0;
    dbl_pulse  = 0;
    bad_change = 0;
    prev_wr    = 1'b0;
    prev_data  = 8'h00;
    prev_rst_n = 1'b0;
    i_rst_n    = 1'b0;
    i_uart_rx  = 1'b1;

    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_midframe();
    test_protocol();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
